// File: rtl/mul_product_accumulator_if.sv
// mul_product_accumulator_if
// Bundles the product-in and total-out streams of the product accumulator.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both 1. Ready/valid driven by the
// accumulator are decoded from its state register only, so neither depends
// combinationally on the opposite side's valid/ready. The producer must hold
// its payload and valid stable until the transfer completes.
//
// Signals:
//   in_valid  - upstream offers `product`
//   in_ready  - accumulator can take a product (ACCUM state)
//   product   - multiplier result, PROD_W bits
//   out_valid - `sum` holds a completed batch total (HOLD state)
//   out_ready - downstream takes the total
//   sum       - running total while accumulating, final total while holding
//   overflow  - sticky saturation flag for the current batch
//
// Modports: slave = accumulator side, master = upstream/downstream side.
interface mul_product_accumulator_if #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  sum;
  logic              overflow;

  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, sum, overflow
  );

  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, sum, overflow
  );
endinterface

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
// Sums a batch of COUNT multiplier products into a saturating accumulator and
// presents the batch total on an output handshake.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   clear    - synchronous batch abort (drops running and held totals)
//   bus      - product-in / total-out streams (slave modport)
//   dbg_hold - 1 while the FSM is in HOLD, 0 in ACCUM
module mul_product_accumulator #(
  parameter int PROD_W = 4,
  parameter int ACC_W  = 8,
  parameter int COUNT  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  mul_product_accumulator_if.slave  bus,
  output logic                      dbg_hold
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  // One extra bit catches the carry out, which is exactly the saturation case.
  logic [ACC_W:0]     add_full;

  assign add_full = {1'b0, sum_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (clear) begin
      // Any product offered alongside clear is swallowed: in_ready stays as
      // decoded from state, so upstream sees the transfer complete.
      state_d = ST_ACCUM;
      sum_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (bus.in_valid) begin
            if (add_full[ACC_W]) begin
              sum_d = '1;
              ovf_d = 1'b1;
            end else begin
              sum_d = add_full[ACC_W-1:0];
            end
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = ST_HOLD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          // A product waiting in HOLD is not taken here even if out_ready is
          // high; it is accepted from ACCUM on the following cycle.
          if (bus.out_ready) begin
            state_d = ST_ACCUM;
            sum_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_ACCUM);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.sum       = sum_q;
  assign bus.overflow  = ovf_q;
  assign dbg_hold      = (state_q == ST_HOLD);

endmodule
